// File: rtl/divbyn_pkg.sv
// divbyn_pkg: shared types and helpers for the divide-by-N sequencer.
// State encoding, mode constants and the half_ceil helper.
package divbyn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // ceil(n/2); odd divisors get the extra high cycle in square mode
  function automatic logic [15:0] half_ceil(input logic [15:0] n);
    return (n >> 1) + {15'd0, n[0]};
  endfunction

endpackage

// File: rtl/divbyn_shadow.sv
// divbyn_shadow: shadow divisor/mode register with pending flag.
// Ports: clk, reset, div_load/div_in/mode_in capture, apply in, nxt_* / pend / load_pend out.
module divbyn_shadow
  import divbyn_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  input  logic             apply,
  output logic [CNT_W-1:0] nxt_div,
  output logic             nxt_mode,
  output logic             pend,
  output logic             load_pend
);

  logic [CNT_W-1:0] sh_div;
  logic             sh_mode;

  // A strobe on the applying edge bypasses the shadow so it lands now
  assign nxt_div  = div_load ? div_in  : sh_div;
  assign nxt_mode = div_load ? mode_in : sh_mode;
  assign pend     = div_load | load_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_div    <= '0;
      sh_mode   <= MODE_PULSE;
      load_pend <= 1'b0;
    end else begin
      if (div_load) begin
        sh_div  <= div_in;
        sh_mode <= mode_in;
      end
      if (apply)
        load_pend <= 1'b0;
      else if (div_load)
        load_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/divbyn_fsm.sv
// divbyn_fsm: runtime-programmable divide-by-N clock-enable source.
// Ports: clk, reset(n), en, div_in/div_load/mode_in, y, tick, cnt, div_cur, load_pend; sclr with DIVBYN_SYNC_CLR_EN.
module divbyn_fsm
  import divbyn_pkg::*;
#(
  parameter int   CNT_W    = 8,
  parameter int   DEF_DIV  = 3,
  parameter logic DEF_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             mode_in,
`ifdef DIVBYN_SYNC_CLR_EN
  input  logic             sclr,
`endif
  output logic             y,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n, div_n;
  logic             mode_cur, mode_n;
  logic             apply, pend, nxt_mode, wrap, clr;
  logic [CNT_W-1:0] nxt_div;

`ifdef DIVBYN_SYNC_CLR_EN
  assign clr = sclr;
`else
  assign clr = 1'b0;
`endif

  divbyn_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .div_load  (div_load),
    .div_in    (div_in),
    .mode_in   (mode_in),
    .apply     (apply),
    .nxt_div   (nxt_div),
    .nxt_mode  (nxt_mode),
    .pend      (pend),
    .load_pend (load_pend)
  );

  // Guarded so div_cur==0 never underflows into a false wrap
  assign wrap = (div_cur != '0) && (cnt == div_cur - ONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    div_n   = div_cur;
    mode_n  = mode_cur;
    apply   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          if (pend) begin
            apply  = 1'b1;
            div_n  = nxt_div;
            mode_n = nxt_mode;
          end
          state_n = (div_n != '0) ? RUN : STALL;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (clr) begin
          cnt_n = '0;
        end else if (wrap) begin
          cnt_n = '0;
          if (pend) begin
            apply  = 1'b1;
            div_n  = nxt_div;
            mode_n = nxt_mode;
          end
          state_n = (div_n != '0) ? RUN : STALL;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STALL: begin
        cnt_n = '0;
        if (!en) begin
          state_n = IDLE;
        end else if (!clr && pend) begin
          apply   = 1'b1;
          div_n   = nxt_div;
          mode_n  = nxt_mode;
          state_n = (div_n != '0) ? RUN : STALL;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= DEF;
      mode_cur <= DEF_MODE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_cur  <= div_n;
      mode_cur <= mode_n;
    end
  end

  always_comb begin
    y    = 1'b0;
    tick = 1'b0;
    if (state == RUN) begin
      tick = wrap;
      if (mode_cur == MODE_SQUARE)
        y = 16'(cnt) < half_ceil(16'(div_cur));
      else
        y = (cnt == '0);
    end
  end

endmodule

// File: tb/tb_divbyn_fsm.sv
// tb_divbyn_fsm: directed scoreboard bench for divbyn_fsm.
// Expected y/tick/cnt/div_cur/load_pend pushed per step, popped after each edge.
module tb_divbyn_fsm;

  typedef struct packed {
    logic       y;
    logic       tick;
    logic [7:0] cnt;
    logic [7:0] dc;
    logic       lp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_in = '0;
  logic       div_load = 1'b0;
  logic       mode_in = 1'b0;
`ifdef DIVBYN_SYNC_CLR_EN
  logic       sclr = 1'b0;
`endif
  logic       y, tick, load_pend;
  logic [7:0] cnt, div_cur;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  divbyn_fsm #(.CNT_W(8), .DEF_DIV(3), .DEF_MODE(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .mode_in   (mode_in),
`ifdef DIVBYN_SYNC_CLR_EN
    .sclr      (sclr),
`endif
    .y         (y),
    .tick      (tick),
    .cnt       (cnt),
    .div_cur   (div_cur),
    .load_pend (load_pend)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(logic ey, logic et, int c, int d, logic p);
    exp_t r;
    r.y = ey; r.tick = et; r.cnt = 8'(c); r.dc = 8'(d); r.lp = p;
    return r;
  endfunction

  task automatic chk(input string tag);
    exp_t got, x;
    got = '{y, tick, cnt, div_cur, load_pend};
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      checks++;
      assert (got === x) else begin
        errors++;
        $error("FAIL %s: got y=%b tick=%b cnt=%0d div=%0d lp=%b, exp y=%b tick=%b cnt=%0d div=%0d lp=%b",
               tag, got.y, got.tick, got.cnt, got.dc, got.lp,
               x.y, x.tick, x.cnt, x.dc, x.lp);
      end
    end
  endtask

  // Drive inputs for one edge, push the expectation, sample #1 after.
  task automatic cyc(input logic e, input logic ld, input int d,
                     input logic m, input exp_t x, input string tag);
    en = e; div_load = ld; div_in = 8'(d); mode_in = m;
    sb.push_back(x);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    #12;
    sb.push_back(E(0, 0, 0, 3, 0));
    chk("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    sb.push_back(E(0, 0, 0, 3, 0));
    chk("idle");

    // defaults N=3 pulse
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "n3_c0");
    cyc(1, 0, 0, 0, E(0, 0, 1, 3, 0), "n3_c1");
    cyc(1, 0, 0, 0, E(0, 1, 2, 3, 0), "n3_c2");
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "n3_c0b");

    // mid-period load N=5 square
    cyc(1, 1, 5, 1, E(0, 0, 1, 3, 1), "ld5_pend");
    cyc(1, 0, 0, 0, E(0, 1, 2, 3, 1), "ld5_old");
    cyc(1, 0, 0, 0, E(1, 0, 0, 5, 0), "sq5_c0");
    cyc(1, 0, 0, 0, E(1, 0, 1, 5, 0), "sq5_c1");
    cyc(1, 0, 0, 0, E(1, 0, 2, 5, 0), "sq5_c2");
    cyc(1, 0, 0, 0, E(0, 0, 3, 5, 0), "sq5_c3");
    cyc(1, 0, 0, 0, E(0, 1, 4, 5, 0), "sq5_c4");
    cyc(1, 0, 0, 0, E(1, 0, 0, 5, 0), "sq5_c0b");

    // load N=0 -> STALL at wrap
    cyc(1, 1, 0, 0, E(1, 0, 1, 5, 1), "ld0_c1");
    cyc(1, 0, 0, 0, E(1, 0, 2, 5, 1), "ld0_c2");
    cyc(1, 0, 0, 0, E(0, 0, 3, 5, 1), "ld0_c3");
    cyc(1, 0, 0, 0, E(0, 1, 4, 5, 1), "ld0_c4");
    cyc(1, 0, 0, 0, E(0, 0, 0, 0, 0), "stall");
    cyc(1, 0, 0, 0, E(0, 0, 0, 0, 0), "stall2");

    // load N=4 pulse leaves STALL on the same edge
    cyc(1, 1, 4, 0, E(1, 0, 0, 4, 0), "p4_c0");
    cyc(1, 0, 0, 0, E(0, 0, 1, 4, 0), "p4_c1");
    cyc(1, 0, 0, 0, E(0, 0, 2, 4, 0), "p4_c2");
    cyc(1, 0, 0, 0, E(0, 1, 3, 4, 0), "p4_c3");
    cyc(1, 0, 0, 0, E(1, 0, 0, 4, 0), "p4_c0b");

    // load N=1
    cyc(1, 1, 1, 0, E(0, 0, 1, 4, 1), "ld1_c1");
    cyc(1, 0, 0, 0, E(0, 0, 2, 4, 1), "ld1_c2");
    cyc(1, 0, 0, 0, E(0, 1, 3, 4, 1), "ld1_c3");
    cyc(1, 0, 0, 0, E(1, 1, 0, 1, 0), "n1_a");
    cyc(1, 0, 0, 0, E(1, 1, 0, 1, 0), "n1_b");
    cyc(0, 0, 0, 0, E(0, 0, 0, 1, 0), "en_off");

    // load while idle is retained, applied when en rises
    cyc(0, 1, 4, 0, E(0, 0, 0, 1, 1), "idle_ld");
    cyc(1, 0, 0, 0, E(1, 0, 0, 4, 0), "idle_apply");

    // two loads before wrap: last wins
    cyc(1, 1, 6, 0, E(0, 0, 1, 4, 1), "ld6");
    cyc(1, 1, 2, 0, E(0, 0, 2, 4, 1), "ld2");
    cyc(1, 0, 0, 0, E(0, 1, 3, 4, 1), "ld2_wait");
    cyc(1, 0, 0, 0, E(1, 0, 0, 2, 0), "n2_c0");
    cyc(1, 0, 0, 0, E(0, 1, 1, 2, 0), "n2_c1");

    // load coincident with wrap edge applies at that wrap
    cyc(1, 1, 3, 1, E(1, 0, 0, 3, 0), "co_c0");
    cyc(1, 0, 0, 0, E(1, 0, 1, 3, 0), "co_c1");
    cyc(1, 0, 0, 0, E(0, 1, 2, 3, 0), "co_c2");
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "co_c0b");

    // pending load then async reset between edges
    cyc(1, 1, 7, 0, E(1, 0, 1, 3, 1), "pre_rst");
    div_load = 1'b0;
    #2 reset = 1'b0;
    #1;
    sb.push_back(E(0, 0, 0, 3, 0));
    chk("async_rst");
    #1 reset = 1'b1;
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "rr_c0");
    cyc(1, 0, 0, 0, E(0, 0, 1, 3, 0), "rr_c1");
    cyc(1, 0, 0, 0, E(0, 1, 2, 3, 0), "rr_c2");
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "rr_c0b");

`ifdef DIVBYN_SYNC_CLR_EN
    cyc(1, 0, 0, 0, E(0, 0, 1, 3, 0), "sc_c1");
    cyc(1, 0, 0, 0, E(0, 1, 2, 3, 0), "sc_c2");
    sclr = 1'b1;
    cyc(1, 0, 0, 0, E(1, 0, 0, 3, 0), "sclr");
    sclr = 1'b0;
    cyc(1, 0, 0, 0, E(0, 0, 1, 3, 0), "sc_after");
`endif

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL leftover: %0d entries, exp 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
